// File: rtl/lenet_pkg.sv
// lenet_pkg: shared image geometry, loader state encoding and frame-position helper.
package lenet_pkg;
  localparam int IMG_DIM = 28;
  localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
  localparam int AW = 5;
  localparam logic [AW-1:0] DIM_MAX = AW'(IMG_DIM - 1);
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} loader_state_e;
  function automatic logic last_pos(input logic [AW-1:0] row, input logic [AW-1:0] col);
    return row == DIM_MAX && col == DIM_MAX;
  endfunction
endpackage

// File: rtl/lenet_pixel_addr_gen.sv
// lenet_pixel_addr_gen: row-major row/col counters for a 28x28 frame with wrap and last flags.
module lenet_pixel_addr_gen
  import lenet_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [AW-1:0] row_o,
  output logic [AW-1:0] col_o,
  output logic          wrap_o,
  output logic          last_o
);
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign wrap_o = col_q == DIM_MAX;
  assign last_o = last_pos(row_q, col_q);
  always_comb begin
    col_d = (clr_i || (inc_i && wrap_o)) ? '0 : inc_i ? col_q + AW'(1) : col_q;
    row_d = (clr_i || (inc_i && last_o)) ? '0 : (inc_i && wrap_o) ? row_q + AW'(1) : row_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/lenet_image_loader.sv
// lenet_image_loader: assembles a serial pixel stream into a held 28x28 frame buffer.
// Define LOADER_LAST_CHECK_EN to check pix_last framing and report it on frame_err.
module lenet_image_loader
  import lenet_pkg::*;
#(
  parameter int BITWIDTH = 4,
  parameter int CNT_W    = 8
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  pix_valid,
  output logic                                                  pix_ready,
  input  logic [BITWIDTH-1:0]                                   pix_data,
  input  logic                                                  pix_last,
  output logic signed [IMG_DIM-1:0][IMG_DIM-1:0][BITWIDTH-1:0] image,
  output logic                                                  frame_valid,
  input  logic                                                  frame_ack,
  output logic [CNT_W-1:0]                                      frame_count,
  output logic                                                  frame_err
);
  loader_state_e state_q, state_d;
  logic signed [IMG_DIM-1:0][IMG_DIM-1:0][BITWIDTH-1:0] image_q;
  logic [CNT_W-1:0] count_q;
  logic [AW-1:0] row, col;
  logic beat, last, clr, unused_wrap;
  assign pix_ready   = state_q == FILL;
  assign frame_valid = state_q == HOLD;
  assign beat        = pix_valid && pix_ready;
  assign image       = image_q;
  assign frame_count = count_q;
  always_comb state_d = (beat && last) ? HOLD : (frame_valid && frame_ack) ? FILL : state_q;
  lenet_pixel_addr_gen u_addr (
    .clk   (clk),
    .reset (reset),
    .inc_i (beat),
    .clr_i (clr),
    .row_o (row),
    .col_o (col),
    .wrap_o(unused_wrap),
    .last_o(last)
  );
`ifdef LOADER_LAST_CHECK_EN
  logic err_q, err_d;
  // an early marker drops the partial frame; a missing one only flags it
  assign clr       = beat && pix_last && !last;
  assign err_d     = err_q || (beat && (pix_last != last));
  assign frame_err = err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
`else
  logic unused_last;
  assign unused_last = pix_last;
  assign clr         = 1'b0;
  assign frame_err   = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      image_q <= '0;
    end else begin
      state_q <= state_d;
      if (beat && last) count_q <= count_q + CNT_W'(1);
      if (beat) image_q[row][col] <= pix_data;
    end
  end
endmodule

// File: tb/tb_lenet_image_loader.sv
// tb_lenet_image_loader: scoreboard and table-driven checks of the frame loader.
module tb_lenet_image_loader;
  logic clk = 1'b0;
  logic reset, pix_valid, pix_ready, pix_last, frame_valid, frame_ack, frame_err;
  logic [3:0] pix_data;
  logic [27:0][27:0][3:0] image;
  logic [7:0] frame_count;
  logic rst2, ready2, last2, fv2, err2;
  logic valid2 = 1'b1, ack2 = 1'b1;
  logic [3:0] data2 = 4'd5;
  logic [27:0][27:0][3:0] image2;
  logic [1:0] cnt2;
  int checks = 0, errors = 0;
  int q[$];
  int exp_img[28][28];
  typedef struct {int r; int c; int v;} spot_t;
  spot_t tbl[6];

  always #5 clk = ~clk;

  lenet_image_loader #(.BITWIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .image(image), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .frame_count(frame_count), .frame_err(frame_err));

  lenet_image_loader #(.BITWIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst2), .pix_valid(valid2), .pix_ready(ready2),
    .pix_data(data2), .pix_last(last2), .image(image2), .frame_valid(fv2),
    .frame_ack(ack2), .frame_count(cnt2), .frame_err(err2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    logic [3:0] t;
    t = image[r][c];
    return int'($signed(t));
  endfunction

  task automatic do_reset();
    int nz = 0;
    reset = 1'b1; pix_valid = 1'b0; pix_last = 1'b0; frame_ack = 1'b0; pix_data = '0;
    @(negedge clk); @(negedge clk); #1;
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) if (px(r, c) != 0) nz++;
    chk("rst_ready", int'(pix_ready), 1);
    chk("rst_valid", int'(frame_valid), 0);
    chk("rst_count", int'(frame_count), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_image_nonzero", nz, 0);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic send(input int n, input int off, input int idle_pct, input int last_at);
    int i = 0, cyc = 0, stalls = 0;
    while (i < n && cyc < 5000) begin
      @(negedge clk);
      pix_valid = ($urandom_range(99) >= idle_pct);
      pix_data  = 4'(((i + off) % 16) - 8);
      pix_last  = (i == last_at);
      #1;
      if (pix_valid && !pix_ready) stalls++;
      if (pix_valid && pix_ready) begin
        q.push_back(((i + off) % 16) - 8);
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    pix_valid = 1'b0; pix_last = 1'b0;
    #1;
    chk("fill_stalls", stalls, 0);
    if (cyc >= 5000) chk("send_timeout", i, n);
  endtask

  task automatic compare_frame(input string name);
    int mism = 0;
    chk({name, "_beats"}, q.size(), 784);
    if (q.size() == 784)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) begin
          exp_img[r][c] = q.pop_front();
          if (px(r, c) != exp_img[r][c]) mism++;
        end
    chk({name, "_mismatches"}, mism, 0);
  endtask

  task automatic do_ack();
    @(negedge clk); frame_ack = 1'b1;
    @(negedge clk); frame_ack = 1'b0;
    #1;
    chk("ack_valid", int'(frame_valid), 0);
    chk("ack_ready", int'(pix_ready), 1);
  endtask

  initial begin
    int hold_rdy, mism, nfr, hi, b2, cyc;
    logic pfv;
    tbl[0] = '{0, 0, -8};  tbl[1] = '{0, 27, 3};  tbl[2] = '{27, 27, 7};
    tbl[3] = '{1, 0, 4};   tbl[4] = '{13, 5, -7}; tbl[5] = '{27, 0, -4};
    rst2 = 1'b1; last2 = 1'b0;
    do_reset();
    // full frame, no gaps
    send(784, 0, 0, 783);
    chk("s1_valid", int'(frame_valid), 1);
    chk("s1_ready", int'(pix_ready), 0);
    chk("s1_count", int'(frame_count), 1);
    compare_frame("s1");
    for (int k = 0; k < 6; k++) chk($sformatf("spot_%0d_%0d", tbl[k].r, tbl[k].c), px(tbl[k].r, tbl[k].c), tbl[k].v);
    // hold against a pushy upstream
    hold_rdy = 0;
    pix_valid = 1'b1;
    repeat (50) begin
      @(negedge clk); pix_data = 4'($urandom); #1;
      if (pix_ready) hold_rdy++;
    end
    pix_valid = 1'b0;
    mism = 0;
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) if (px(r, c) != exp_img[r][c]) mism++;
    chk("hold_ready", hold_rdy, 0);
    chk("hold_valid", int'(frame_valid), 1);
    chk("hold_image", mism, 0);
    chk("hold_count", int'(frame_count), 1);
    do_ack();
    // idle gaps
    send(784, 0, 30, 783);
    chk("s3_valid", int'(frame_valid), 1);
    chk("s3_count", int'(frame_count), 2);
    compare_frame("s3");
    do_ack();
    // reset mid-frame
    send(400, 3, 0, -1);
    chk("s4_mid_valid", int'(frame_valid), 0);
    do_reset();
    send(784, 7, 0, 783);
    chk("s4_valid", int'(frame_valid), 1);
    chk("s4_count", int'(frame_count), 1);
    compare_frame("s4");
    do_ack();
`ifdef LOADER_LAST_CHECK_EN
    send(100, 2, 0, 99);
    chk("s5_early_err", int'(frame_err), 1);
    chk("s5_early_valid", int'(frame_valid), 0);
    chk("s5_early_count", int'(frame_count), 1);
    q.delete();
    send(784, 9, 20, 783);
    chk("s5_valid", int'(frame_valid), 1);
    chk("s5_count", int'(frame_count), 2);
    chk("s5_err_sticky", int'(frame_err), 1);
    compare_frame("s5");
    do_reset();
    send(784, 4, 0, -1);
    chk("s5_nolast_err", int'(frame_err), 1);
    chk("s5_nolast_valid", int'(frame_valid), 1);
    chk("s5_nolast_count", int'(frame_count), 1);
    compare_frame("s5b");
`else
    send(784, 2, 0, 99);
    chk("s5_ign_valid", int'(frame_valid), 1);
    chk("s5_ign_count", int'(frame_count), 2);
    chk("s5_ign_err", int'(frame_err), 0);
    compare_frame("s5");
`endif
    // back-to-back frames with ack held high; 2-bit counter wraps
    @(negedge clk); rst2 = 1'b0;
    nfr = 0; hi = 0; b2 = 0; cyc = 0; pfv = 1'b0;
    while (nfr < 5 && cyc < 5000) begin
      @(negedge clk);
      last2 = (b2 == 783);
      #1;
      if (ready2) b2 = (b2 == 783) ? 0 : b2 + 1;
      if (fv2) hi++;
      if (fv2 && !pfv) begin
        nfr++;
        chk($sformatf("wrap_count_%0d", nfr), int'(cnt2), nfr % 4);
      end
      if (!fv2 && pfv) begin
        chk("fv_width", hi, 1);
        hi = 0;
      end
      pfv = fv2;
      cyc++;
    end
    chk("wrap_frames", nfr, 5);
    chk("wrap_err", int'(err2), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
